// File: rtl/dac_serializer.sv
// Dual-channel serial DAC transmitter: captures X/Y codes on sample, shifts a
// 16-bit frame per channel, then pulses ldacn so both analog outputs update together.
module dac_serializer #(
  parameter int DIVIDE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [10:1]  xdac,
  input  logic         xvld,
  input  logic [10:1]  ydac,
  input  logic         yvld,
  input  logic         sample,
  input  logic         clr_ovr,
  output logic         sclk,
  output logic         sdata,
  output logic         csn,
  output logic         ldacn,
  output logic         beam_on,
  output logic         busy,
  output logic         overrun
);

  typedef enum logic [2:0] {
    IDLE,
    XSHIFT,
    GAP,
    YSHIFT,
    LDAC
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(DIVIDE - 1);

  // Frame: channel bit, 2'b01 command, 10-bit code, three pad zeros.
  function automatic logic [15:0] make_frame(input logic ch, input logic [9:0] code);
    return {ch, 2'b01, code, 3'b000};
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic [9:0]  ycode_q, ycode_d;
  logic        xvld_q, xvld_d;
  logic        yvld_q, yvld_d;
  logic        sclk_q, sclk_d;
  logic        csn_q, csn_d;
  logic        ldacn_q, ldacn_d;
  logic        beam_q, beam_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;

  logic        cnt_last;
  logic        accept;
  logic        drop;

  assign cnt_last = (cnt_q == DIV_LAST);

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ycode_d = ycode_q;
    xvld_d  = xvld_q;
    yvld_d  = yvld_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    ldacn_d = ldacn_q;
    beam_d  = beam_q;
    busy_d  = busy_q;
    accept  = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        accept = sample;
      end

      XSHIFT, YSHIFT: begin
        drop  = sample;
        cnt_d = cnt_q + 8'd1;
        if (cnt_last) begin
          cnt_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              csn_d = 1'b1;
              if (state_q == XSHIFT) begin
                state_d = GAP;
              end else begin
                state_d = LDAC;
                ldacn_d = 1'b0;
              end
            end else begin
              // Data only moves on the falling sclk edge, so it is stable across the rise.
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
      end

      GAP: begin
        drop  = sample;
        cnt_d = cnt_q + 8'd1;
        if (cnt_last) begin
          cnt_d   = 8'd0;
          state_d = YSHIFT;
          csn_d   = 1'b0;
          bit_d   = 4'd15;
          shreg_d = make_frame(1'b1, ycode_q);
        end
      end

      LDAC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_last) begin
          // The exit edge behaves as idle: a waiting sample starts the next transfer.
          cnt_d   = 8'd0;
          ldacn_d = 1'b1;
          beam_d  = xvld_q & yvld_q;
          busy_d  = 1'b0;
          state_d = IDLE;
          accept  = sample;
        end else begin
          drop = sample;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      ycode_d = ydac;
      xvld_d  = xvld;
      yvld_d  = yvld;
      shreg_d = make_frame(1'b0, xdac);
      sclk_d  = 1'b0;
      csn_d   = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = 8'd0;
      bit_d   = 4'd15;
      state_d = XSHIFT;
    end

    // A drop on the same edge as clr_ovr wins.
    ovr_d = clr_ovr ? 1'b0 : ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 4'd0;
      shreg_q <= 16'd0;
      ycode_q <= 10'd0;
      xvld_q  <= 1'b0;
      yvld_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      ldacn_q <= 1'b1;
      beam_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ycode_q <= ycode_d;
      xvld_q  <= xvld_d;
      yvld_q  <= yvld_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      ldacn_q <= ldacn_d;
      beam_q  <= beam_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sclk    = sclk_q;
  assign sdata   = shreg_q[15];
  assign csn     = csn_q;
  assign ldacn   = ldacn_q;
  assign beam_on = beam_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Directed bench for dac_serializer: one instance at DIVIDE=4, one at DIVIDE=1,
// outputs sampled on the falling clk edge.
module tb_dac_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:1] xdac, ydac;
  logic        xvld, yvld;
  logic        sample4, sample1;
  logic        clr_ovr;

  logic sclk4, sdata4, csn4, ldacn4, beam4, busy4, ovr4;
  logic sclk1, sdata1, csn1, ldacn1, beam1, busy1, ovr1;

  logic sel;
  int   h;
  int   passed = 0;
  int   total  = 0;

  logic sclk_m, sdata_m, csn_m, ldacn_m, beam_m, busy_m, ovr_m;
  assign sclk_m  = sel ? sclk1  : sclk4;
  assign sdata_m = sel ? sdata1 : sdata4;
  assign csn_m   = sel ? csn1   : csn4;
  assign ldacn_m = sel ? ldacn1 : ldacn4;
  assign beam_m  = sel ? beam1  : beam4;
  assign busy_m  = sel ? busy1  : busy4;
  assign ovr_m   = sel ? ovr1   : ovr4;

  always #5 clk = ~clk;

  dac_serializer #(.DIVIDE(4)) u_dut4 (
    .clk(clk), .reset(reset), .xdac(xdac), .xvld(xvld), .ydac(ydac), .yvld(yvld),
    .sample(sample4), .clr_ovr(clr_ovr), .sclk(sclk4), .sdata(sdata4), .csn(csn4),
    .ldacn(ldacn4), .beam_on(beam4), .busy(busy4), .overrun(ovr4)
  );

  dac_serializer #(.DIVIDE(1)) u_dut1 (
    .clk(clk), .reset(reset), .xdac(xdac), .xvld(xvld), .ydac(ydac), .yvld(yvld),
    .sample(sample1), .clr_ovr(clr_ovr), .sclk(sclk1), .sdata(sdata1), .csn(csn1),
    .ldacn(ldacn1), .beam_on(beam1), .busy(busy1), .overrun(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_sample(input logic v);
    if (sel) sample1 = v;
    else sample4 = v;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && busy_m; i++) @(negedge clk);
    check({tag, " idle_wait"}, 32'(busy_m), 32'd0);
  endtask

  // One complete single-pulse transfer; codes and flags are scrambled at
  // cycle 10 to show that only the captured values are used.
  task automatic do_transfer(input logic [9:0] xd, input logic [9:0] yd,
                             input logic xv, input logic yv,
                             input logic [15:0] exp_x, input logic [15:0] exp_y,
                             input logic exp_beam, input string tag);
    logic [15:0] xlo, xhi, ylo, yhi, xsck;
    int ld_first, ld_cnt;
    logic busy0, csn0, csn_gap, busy_end, beam_end;
    xlo = '0; xhi = '0; ylo = '0; yhi = '0; xsck = '0;
    ld_first = -1; ld_cnt = 0;
    busy0 = 1'b0; csn0 = 1'b1; csn_gap = 1'b0; busy_end = 1'b1; beam_end = 1'b0;
    xdac = xd; ydac = yd; xvld = xv; yvld = yv;
    set_sample(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_sample(1'b0);
    for (int c = 0; c <= 66 * h; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        busy0 = busy_m;
        csn0  = csn_m;
      end
      if (c == 10) begin
        xdac = ~xd; ydac = ~yd; xvld = ~xv; yvld = ~yv;
      end
      if (c < 32 * h) begin
        if (c % (2 * h) == h - 1) xlo[15 - c / (2 * h)] = sdata_m;
        if (c % (2 * h) == h) begin
          xhi[15 - c / (2 * h)]  = sdata_m;
          xsck[15 - c / (2 * h)] = sclk_m;
        end
      end else if (c >= 33 * h && c < 65 * h) begin
        if ((c - 33 * h) % (2 * h) == h - 1) ylo[15 - (c - 33 * h) / (2 * h)] = sdata_m;
        if ((c - 33 * h) % (2 * h) == h)     yhi[15 - (c - 33 * h) / (2 * h)] = sdata_m;
      end
      if (!ldacn_m) begin
        if (ld_cnt == 0) ld_first = c;
        ld_cnt++;
      end
      if (c == 32 * h) csn_gap = csn_m;
      if (c == 66 * h) begin
        busy_end = busy_m;
        beam_end = beam_m;
      end
    end
    check({tag, " busy_at_accept"}, 32'(busy0), 32'd1);
    check({tag, " csn_at_accept"}, 32'(csn0), 32'd0);
    check({tag, " x_before_rise"}, 32'(xlo), 32'(exp_x));
    check({tag, " x_after_rise"}, 32'(xhi), 32'(exp_x));
    check({tag, " sclk_high_phase"}, 32'(xsck), 32'hFFFF);
    check({tag, " csn_gap"}, 32'(csn_gap), 32'd1);
    check({tag, " y_before_rise"}, 32'(ylo), 32'(exp_y));
    check({tag, " y_after_rise"}, 32'(yhi), 32'(exp_y));
    check({tag, " ldacn_first"}, 32'(ld_first), 32'(65 * h));
    check({tag, " ldacn_len"}, 32'(ld_cnt), 32'(h));
    check({tag, " busy_end"}, 32'(busy_end), 32'd0);
    check({tag, " beam_end"}, 32'(beam_end), 32'(exp_beam));
  endtask

  initial begin
    reset = 1'b1; xdac = '0; ydac = '0; xvld = 1'b0; yvld = 1'b0;
    sample4 = 1'b0; sample1 = 1'b0; clr_ovr = 1'b0;
    sel = 1'b0; h = 4;

    repeat (2) @(negedge clk);
    check("rst sclk", 32'(sclk4), 32'd0);
    check("rst sdata", 32'(sdata4), 32'd0);
    check("rst csn", 32'(csn4), 32'd1);
    check("rst ldacn", 32'(ldacn4), 32'd1);
    check("rst beam", 32'(beam4), 32'd0);
    check("rst busy", 32'(busy4), 32'd0);
    check("rst ovr", 32'(ovr4), 32'd0);
    check("rst h1 csn", 32'(csn1), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_transfer(10'h2AB, 10'h155, 1'b1, 1'b1, 16'h3558, 16'hAAA8, 1'b1, "t1");
    repeat (3) @(negedge clk);
    do_transfer(10'h2AB, 10'h155, 1'b1, 1'b0, 16'h3558, 16'hAAA8, 1'b0, "t2_yinval");
    do_transfer(10'h2AB, 10'h155, 1'b1, 1'b1, 16'h3558, 16'hAAA8, 1'b1, "t3");

    // Sample held high: first capture has yvld=0, second (at 264) has yvld=1.
    check("held ovr_pre", 32'(ovr4), 32'd0);
    xvld = 1'b1; yvld = 1'b0;
    sample4 = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 264; c++) begin
      @(negedge clk);
      if (c == 0) check("held csn_c0", 32'(csn4), 32'd0);
      if (c == 1) begin
        check("held ovr_c1", 32'(ovr4), 32'd1);
        yvld = 1'b1;
      end
      if (c == 263) begin
        check("held busy_c263", 32'(busy4), 32'd1);
        check("held ldacn_c263", 32'(ldacn4), 32'd0);
      end
      if (c == 264) begin
        check("held csn_c264", 32'(csn4), 32'd0);
        check("held busy_c264", 32'(busy4), 32'd1);
        check("held ldacn_c264", 32'(ldacn4), 32'd1);
        check("held beam_c264", 32'(beam4), 32'd0);
      end
    end
    sample4 = 1'b0;
    wait_idle(400, "held");
    check("held beam_second", 32'(beam4), 32'd1);
    check("held ovr_sticky", 32'(ovr4), 32'd1);

    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("clr ovr_idle", 32'(ovr4), 32'd0);

    sample4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample4 = 1'b0;
    repeat (4) @(negedge clk);
    sample4 = 1'b1; clr_ovr = 1'b1;
    @(negedge clk);
    sample4 = 1'b0; clr_ovr = 1'b0;
    check("setwins ovr", 32'(ovr4), 32'd1);
    wait_idle(300, "setwins");

    // Asynchronous reset in the middle of the Y frame.
    xvld = 1'b1; yvld = 1'b1;
    sample4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample4 = 1'b0;
    repeat (150) @(negedge clk);
    check("midrst csn_pre", 32'(csn4), 32'd0);
    #1 reset = 1'b1;
    #1;
    check("midrst sclk", 32'(sclk4), 32'd0);
    check("midrst sdata", 32'(sdata4), 32'd0);
    check("midrst csn", 32'(csn4), 32'd1);
    check("midrst ldacn", 32'(ldacn4), 32'd1);
    check("midrst beam", 32'(beam4), 32'd0);
    check("midrst busy", 32'(busy4), 32'd0);
    check("midrst ovr", 32'(ovr4), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_transfer(10'h2AB, 10'h155, 1'b1, 1'b1, 16'h3558, 16'hAAA8, 1'b1, "t_after_rst");

    sel = 1'b1; h = 1;
    @(negedge clk);
    do_transfer(10'h3FF, 10'h000, 1'b1, 1'b1, 16'h3FF8, 16'hA000, 1'b1, "h1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
